// File: rtl/serv_shift_seq.sv
// Bit-serial shift sequencer: captures shamt/sign from the LSB-first operand streams, pulses the
// shifter load, rotates the data buffer until done, then frames the XLEN-cycle writeback phase.
module serv_shift_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_right,
  input  logic       i_arith,
  input  logic       i_op_a,
  input  logic       i_op_b,
  input  logic       i_done,
  output logic [4:0] o_shamt,
  output logic       o_shamt_msb,
  output logic       o_signbit,
  output logic       o_right,
  output logic       o_load,
  output logic       o_cap_en,
  output logic       o_shift_en,
  output logic       o_rd_en,
  output logic       o_busy,
  output logic       o_ready,
  output logic       o_timeout
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntMax = CntW'(XLEN - 1);

  typedef enum logic [2:0] {StIdle, StCapture, StLoad, StCount, StResult} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            arith;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= StIdle;
      cnt         <= '0;
      arith       <= 1'b0;
      o_shamt     <= '0;
      o_shamt_msb <= 1'b0;
      o_signbit   <= 1'b0;
      o_right     <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (i_start) begin
            o_right     <= i_right;
            arith       <= i_arith;
            o_shamt     <= '0;
            o_shamt_msb <= 1'b0;
            o_signbit   <= 1'b0;
            o_timeout   <= 1'b0;
            cnt         <= '0;
            state       <= StCapture;
          end
        end
        StCapture: begin
          // Only the low six operand-B bits matter; the rest of the stream is ignored.
          if (cnt < CntW'(5)) begin
            o_shamt[cnt[2:0]] <= i_op_b;
          end else if (cnt == CntW'(5)) begin
            o_shamt_msb <= i_op_b;
          end
          if (cnt == CntMax) begin
            o_signbit <= i_op_a & arith;
            cnt       <= '0;
            state     <= StLoad;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StLoad: begin
          cnt   <= '0;
          state <= StCount;
        end
        StCount: begin
          if (i_done) begin
            cnt   <= '0;
            state <= StResult;
          end else if (cnt == CntMax) begin
            o_timeout <= 1'b1;
            cnt       <= '0;
            state     <= StResult;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StResult: begin
          if (cnt == CntMax) begin
            cnt   <= '0;
            state <= StIdle;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= StIdle;
        end
      endcase
    end
  end

  assign o_cap_en   = (state == StCapture);
  assign o_load     = (state == StLoad);
  assign o_shift_en = (state == StCount);
  assign o_rd_en    = (state == StResult);
  assign o_busy     = (state != StIdle);
  assign o_ready    = (state == StResult) && (cnt == CntMax);

endmodule
